// File: rtl/wb_arb_pkg.sv
// Shared types for the two-master Wishbone arbiter: FSM state encoding,
// master count and the state-to-grant decode.
package wb_arb_pkg;

  localparam int NB_MASTERS = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  function automatic logic [NB_MASTERS-1:0] state_to_gnt(input state_t s);
    case (s)
      GNT0:    return 2'b01;
      GNT1:    return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/wshb_if.sv
// Wishbone bundle: 32-bit address/data, 4-bit byte select, cti/bte burst tags.
interface wshb_if;

  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] adr;
  logic [31:0] dat_ms;
  logic [31:0] dat_sm;
  logic [3:0]  sel;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic        ack;
  logic        err;

  modport master (output cyc, stb, we, adr, dat_ms, sel, cti, bte,
                  input  dat_sm, ack, err);
  modport slave  (input  cyc, stb, we, adr, dat_ms, sel, cti, bte,
                  output dat_sm, ack, err);

endinterface

// File: rtl/wb_arb_fsm.sv
// Grant FSM: registered owner and priority; the owner keeps the bus for as
// long as it holds cyc, and a waiting master takes over without an idle cycle.
module wb_arb_fsm
  import wb_arb_pkg::*;
#(
  parameter int RR        = 1,
  parameter int INIT_PRIO = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NB_MASTERS-1:0] cyc_i,
  output logic [NB_MASTERS-1:0] gnt_o
);

  state_t state_q, state_d;
  logic   prio_q, prio_d;
  logic   prio_eff;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      prio_q  <= 1'(INIT_PRIO);
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
    end
  end

  // With fixed priority master 0 always wins a tie.
  assign prio_eff = (RR != 0) ? prio_q : 1'b0;

  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    case (state_q)
      IDLE: begin
        if (cyc_i[0] && cyc_i[1]) state_d = prio_eff ? GNT1 : GNT0;
        else if (cyc_i[0])        state_d = GNT0;
        else if (cyc_i[1])        state_d = GNT1;
      end
      GNT0:    if (!cyc_i[0]) state_d = cyc_i[1] ? GNT1 : IDLE;
      GNT1:    if (!cyc_i[1]) state_d = cyc_i[0] ? GNT0 : IDLE;
      default: state_d = IDLE;
    endcase
    // A fresh grant hands priority to the master that did not get the bus.
    if (state_d != state_q) begin
      if (state_d == GNT0)      prio_d = (RR != 0);
      else if (state_d == GNT1) prio_d = 1'b0;
    end
  end

  assign gnt_o = state_to_gnt(state_q);

endmodule

// File: rtl/wb_arbiter.sv
// Two-master Wishbone arbiter: the grant FSM picks the owner, this level muxes
// the owner onto the shared target with no added latency.
module wb_arbiter
  import wb_arb_pkg::*;
#(
  parameter int RR        = 1,
  parameter int INIT_PRIO = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  wshb_if.slave                 wb_m0,
  wshb_if.slave                 wb_m1,
  wshb_if.master                wb_s,
  output logic [NB_MASTERS-1:0] gnt
);

  logic sel0, sel1;

  wb_arb_fsm #(
    .RR        (RR),
    .INIT_PRIO (INIT_PRIO)
  ) u_fsm (
    .clk   (clk),
    .rst   (rst),
    .cyc_i ({wb_m1.cyc, wb_m0.cyc}),
    .gnt_o (gnt)
  );

  assign sel0 = gnt[0];
  assign sel1 = gnt[1];

  // Idle bus drives all request fields to zero.
  assign wb_s.cyc    = sel0 ? wb_m0.cyc    : (sel1 ? wb_m1.cyc    : 1'b0);
  assign wb_s.stb    = sel0 ? wb_m0.stb    : (sel1 ? wb_m1.stb    : 1'b0);
  assign wb_s.we     = sel0 ? wb_m0.we     : (sel1 ? wb_m1.we     : 1'b0);
  assign wb_s.adr    = sel0 ? wb_m0.adr    : (sel1 ? wb_m1.adr    : 32'h0);
  assign wb_s.dat_ms = sel0 ? wb_m0.dat_ms : (sel1 ? wb_m1.dat_ms : 32'h0);
  assign wb_s.sel    = sel0 ? wb_m0.sel    : (sel1 ? wb_m1.sel    : 4'h0);
  assign wb_s.cti    = sel0 ? wb_m0.cti    : (sel1 ? wb_m1.cti    : 3'h0);
  assign wb_s.bte    = sel0 ? wb_m0.bte    : (sel1 ? wb_m1.bte    : 2'h0);

  // Read data is broadcast; only the owner ever sees ack or err.
  assign wb_m0.dat_sm = wb_s.dat_sm;
  assign wb_m1.dat_sm = wb_s.dat_sm;
  assign wb_m0.ack    = sel0 & wb_s.ack;
  assign wb_m1.ack    = sel1 & wb_s.ack;
  assign wb_m0.err    = sel0 & wb_s.err;
  assign wb_m1.err    = sel1 & wb_s.err;

endmodule
